// File: rtl/ibex_instr_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ibex_instr_mem_responder                                        |
// | Purpose  : Responder end of the instruction-fetch req/gnt/rvalid protocol. |
// |            Grants fetches under a stall policy and an outstanding limit,   |
// |            reads a synchronous single-port SRAM and returns words in       |
// |            grant order with a programmable minimum latency.                |
// | Options  : IBEX_IMEM_RAND_STALL_EN - LFSR-driven random grant/rvalid       |
// |            stalls; when undefined the timing is fully deterministic.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ibex_instr_mem_responder #(
   parameter int ADDR_W          = 12,
   parameter int MAX_OUTSTANDING = 2,
   parameter int GNT_STALL       = 0,
   parameter int RVALID_LATENCY  = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              instr_req_i,
   input  logic [31:0]       instr_addr_i,
   output logic              instr_gnt_o,
   output logic              instr_rvalid_o,
   output logic [31:0]       instr_rdata_o,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic [31:0]       mem_rdata_i,
   output logic              busy_o
);

   localparam int c_PTR_W   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int c_OCNT_W  = $clog2(MAX_OUTSTANDING + 1);
   localparam int c_LAT_W   = (RVALID_LATENCY > 1) ? $clog2(RVALID_LATENCY) : 1;
   localparam int c_STALL_W = (GNT_STALL > 0) ? $clog2(GNT_STALL + 1) : 1;

   localparam logic [c_PTR_W-1:0]   c_PTR_LAST  = c_PTR_W'(MAX_OUTSTANDING - 1);
   localparam logic [c_OCNT_W-1:0]  c_OUT_MAX   = c_OCNT_W'(MAX_OUTSTANDING);
   localparam logic [c_LAT_W-1:0]   c_LAT_LOAD  = c_LAT_W'(RVALID_LATENCY - 1);
   localparam logic [c_STALL_W-1:0] c_STALL_MAX = c_STALL_W'(GNT_STALL);

   // Response queue: one slot per outstanding request, written at wptr on
   // grant and retired from rptr on rvalid.
   logic [c_OCNT_W-1:0]      r_outstanding;
   logic [c_PTR_W-1:0]       r_wptr;
   logic [c_PTR_W-1:0]       r_rptr;
   logic [c_LAT_W-1:0]       r_lat  [MAX_OUTSTANDING];
   logic [31:0]              r_data [MAX_OUTSTANDING];
   logic [MAX_OUTSTANDING-1:0] r_dvld;

   // SRAM data lands one cycle after the grant; remember which slot it is for.
   logic                     r_cap_pending;
   logic [c_PTR_W-1:0]       r_cap_ptr;

   logic [31:0]              r_rdata_hold;

   logic                     w_stall_ok;
   logic                     w_out_ok;
   logic                     w_rand_gnt_ok;
   logic                     w_rand_rv_ok;
   logic                     w_gnt;
   logic                     w_head_has_data;
   logic                     w_head_ready;
   logic                     w_pop;
   logic [31:0]              w_head_data;
   logic                     w_unused;

   function automatic logic [c_PTR_W-1:0] f_next_ptr(input logic [c_PTR_W-1:0] p);
      return (p == c_PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   // Word index only; byte offset and high address bits are ignored.
   assign w_unused = ^{instr_addr_i[31:ADDR_W+2], instr_addr_i[1:0]};

   // ------------------------------------------------------------------------
   // Grant stall counter
   // ------------------------------------------------------------------------
   if (GNT_STALL > 0) begin : g_stall
      logic [c_STALL_W-1:0] r_stall_cnt;

      // Count held-but-ungranted request cycles, saturating at GNT_STALL.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_stall_cnt <= '0;
         end else if (!instr_req_i || w_gnt) begin
            r_stall_cnt <= '0;
         end else if (r_stall_cnt != c_STALL_MAX) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
      end

      assign w_stall_ok = (r_stall_cnt >= c_STALL_MAX);
   end else begin : g_no_stall
      assign w_stall_ok = 1'b1;
   end

   // ------------------------------------------------------------------------
   // Optional random stall source
   // ------------------------------------------------------------------------
`ifdef IBEX_IMEM_RAND_STALL_EN
   logic [15:0] r_lfsr;

   // Fibonacci LFSR, taps 16/14/13/11, free-running from a fixed seed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lfsr <= 16'hACE1;
      end else begin
         r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
      end
   end

   assign w_rand_gnt_ok = (r_lfsr[1:0] != 2'b00);
   assign w_rand_rv_ok  = (r_lfsr[3:2] != 2'b00);
`else
   assign w_rand_gnt_ok = 1'b1;
   assign w_rand_rv_ok  = 1'b1;
`endif

   // ------------------------------------------------------------------------
   // Grant and response selection
   // ------------------------------------------------------------------------
   // A pop in this cycle is deliberately not counted: no full bypass.
   assign w_out_ok = (r_outstanding < c_OUT_MAX);
   assign w_gnt    = instr_req_i & w_stall_ok & w_out_ok & w_rand_gnt_ok;

   // Head data is either already stored or arriving from the SRAM right now.
   assign w_head_has_data = r_dvld[r_rptr] | (r_cap_pending & (r_cap_ptr == r_rptr));
   assign w_head_data     = r_dvld[r_rptr] ? r_data[r_rptr] : mem_rdata_i;
   assign w_head_ready    = (r_outstanding != '0) & (r_lat[r_rptr] == '0) & w_head_has_data;
   assign w_pop           = w_head_ready & w_rand_rv_ok;

   assign instr_gnt_o    = w_gnt;
   assign instr_rvalid_o = w_pop;
   assign instr_rdata_o  = w_pop ? w_head_data : r_rdata_hold;
   assign mem_req_o      = w_gnt;
   assign mem_addr_o     = instr_addr_i[ADDR_W+1:2];
   assign busy_o         = (r_outstanding != '0);

   // ------------------------------------------------------------------------
   // Sequential state
   // ------------------------------------------------------------------------
   // Track occupancy and advance queue pointers on grant / pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_outstanding <= '0;
         r_wptr        <= '0;
         r_rptr        <= '0;
      end else begin
         case ({w_gnt, w_pop})
            2'b10:   r_outstanding <= r_outstanding + 1'b1;
            2'b01:   r_outstanding <= r_outstanding - 1'b1;
            default: r_outstanding <= r_outstanding;
         endcase
         if (w_gnt) r_wptr <= f_next_ptr(r_wptr);
         if (w_pop) r_rptr <= f_next_ptr(r_rptr);
      end
   end

   // Remember the slot whose SRAM data arrives in the next cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cap_pending <= 1'b0;
         r_cap_ptr     <= '0;
      end else begin
         r_cap_pending <= w_gnt;
         r_cap_ptr     <= r_wptr;
      end
   end

   // Per-slot latency countdown and data-valid flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            r_lat[i] <= '0;
         end
         r_dvld <= '0;
      end else begin
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (w_gnt && (r_wptr == c_PTR_W'(i))) begin
               r_lat[i]  <= c_LAT_LOAD;
               r_dvld[i] <= 1'b0;
            end else begin
               if (r_lat[i] != '0) r_lat[i] <= r_lat[i] - 1'b1;
               if (r_cap_pending && (r_cap_ptr == c_PTR_W'(i))) r_dvld[i] <= 1'b1;
            end
         end
      end
   end

   // Capture SRAM read data into its slot; payload needs no reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
         if (r_cap_pending && (r_cap_ptr == c_PTR_W'(i))) r_data[i] <= mem_rdata_i;
      end
   end

   // Keep the last returned word visible while rvalid is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata_hold <= '0;
      end else if (w_pop) begin
         r_rdata_hold <= w_head_data;
      end
   end

endmodule
`default_nettype wire
